// File: rtl/mem_arbiter_2port.sv
// mem_arbiter_2port
//   Round-robin arbiter and sequencer that shares one single-port synchronous
//   memory between requester A (CPU side) and requester B (loader/DMA side).
//   The memory port (cs/wen/addr/din) is driven from registers. Read data comes
//   back one cycle after the access and is flagged per requester by x_rvalid.
//
// Ports
//   clk                 single clock, rising edge
//   reset               asynchronous, active-low reset
//   a_req / b_req       request level, held with stable wen/addr/din until ack
//   a_wen / b_wen       1 = write, 0 = read
//   a_addr / b_addr     access address
//   a_din / b_din       write data
//   a_ack / b_ack       one-cycle pulse: the access is on the memory this cycle
//   a_rvalid / b_rvalid one-cycle pulse: rdata holds that requester's read data
//   rdata               combinational pass-through of mem_dout
//   mem_cs / mem_wen    memory chip select / write enable (registered)
//   mem_addr / mem_din  memory address / write data (registered)
//   mem_dout            memory read data
module mem_arbiter_2port #(
    parameter int WIDTH     = 8,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_req,
    input  logic                 a_wen,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [WIDTH-1:0]     a_din,
    input  logic                 b_req,
    input  logic                 b_wen,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [WIDTH-1:0]     b_din,
    output logic                 a_ack,
    output logic                 b_ack,
    output logic                 a_rvalid,
    output logic                 b_rvalid,
    output logic [WIDTH-1:0]     rdata,
    output logic                 mem_cs,
    output logic                 mem_wen,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_din,
    input  logic [WIDTH-1:0]     mem_dout
);

    typedef enum logic {IDLE, ISSUE} state_e;
    typedef enum logic {REQ_A, REQ_B} who_e;

    state_e                state_q, state_d;
    who_e                  owner_q, owner_d;
    who_e                  prio_q, prio_d;
    logic                  mem_cs_q, mem_cs_d;
    logic                  mem_wen_q, mem_wen_d;
    logic [ADDR_SIZE-1:0]  mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]      mem_din_q, mem_din_d;
    logic                  rv_a_q, rv_a_d;
    logic                  rv_b_q, rv_b_d;

    logic                  serving_a;
    logic                  serving_b;
    logic                  elig_a;
    logic                  elig_b;
    logic                  win_b;
    logic                  grant;

    always_comb begin
        serving_a = (state_q == ISSUE) && (owner_q == REQ_A);
        serving_b = (state_q == ISSUE) && (owner_q == REQ_B);

        // A requester is masked during its own ack cycle so a held req
        // cannot be granted twice for the same access.
        elig_a = a_req && !serving_a;
        elig_b = b_req && !serving_b;

        // B wins when it is the only candidate or when it holds the tie priority.
        win_b  = elig_b && (!elig_a || (prio_q == REQ_B));
        grant  = elig_a || elig_b;

        state_d    = IDLE;
        owner_d    = owner_q;
        prio_d     = prio_q;
        mem_cs_d   = 1'b0;
        mem_wen_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;

        // Read results land in mem_dout one cycle after the read access.
        rv_a_d = serving_a && !mem_wen_q;
        rv_b_d = serving_b && !mem_wen_q;

        if (grant) begin
            state_d  = ISSUE;
            owner_d  = win_b ? REQ_B : REQ_A;
            prio_d   = win_b ? REQ_A : REQ_B;
            mem_cs_d = 1'b1;
            if (win_b) begin
                mem_wen_d  = b_wen;
                mem_addr_d = b_addr;
                mem_din_d  = b_din;
            end else begin
                mem_wen_d  = a_wen;
                mem_addr_d = a_addr;
                mem_din_d  = a_din;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= REQ_A;
            prio_q     <= REQ_A;
            mem_cs_q   <= 1'b0;
            mem_wen_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rv_a_q     <= 1'b0;
            rv_b_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            mem_cs_q   <= mem_cs_d;
            mem_wen_q  <= mem_wen_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rv_a_q     <= rv_a_d;
            rv_b_q     <= rv_b_d;
        end
    end

    assign a_ack    = serving_a;
    assign b_ack    = serving_b;
    assign a_rvalid = rv_a_q;
    assign b_rvalid = rv_b_q;
    assign rdata    = mem_dout;
    assign mem_cs   = mem_cs_q;
    assign mem_wen  = mem_wen_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule
